mips_hazard_controller: RTL and testbench
=========================================

# mips_hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the decode control unit and drives the PC load, pipeline-register enables and flush lines. It resolves load-use hazards, multi-cycle MUL occupancy of the EX stage, taken branches resolved in MA, and jumps decoded in ID. It owns a small FSM that paces the fixed-latency multiplier, plus a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MUL_LATENCY, 4: cycles a MUL spends in EX; must be ≥2.
- CNT_W, 32: width of the stall counter.

Ports:
- clk  in  1  single core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemReadE  in  1  instruction in EX is a load.
- rtE  in  5  load destination register in EX.
- rsD  in  5  rs field of the instruction in ID.
- rtD  in  5  rt field of the instruction in ID.
- useRtD  in  1  instruction in ID reads rt (R-type, beq, bne, sw).
- mulE  in  1  instruction in EX is MUL (ALUOp = 3'b010).
- branch_takenM  in  1  branch in MA is taken.
- select_jumpD  in  1  jump decoded in ID.
- PC_load  out  1  PC register load enable.
- EN_to_pipelineReg1  out  1  IF/ID enable.
- EN_to_pipelineReg2  out  1  ID/EX enable.
- flushD, flushE, flushM  out  1 each  synchronous clears of IF/ID, ID/EX and EX/MA (insert bubble).
- mul_start  out  1  one-cycle pulse that starts the multiplier.
- mul_busy  out  1  FSM is in MUL_BUSY.
- stall_count  out  CNT_W  cycles with PC_load=0, saturating.

## Operation
- FSM states: IDLE, MUL_BUSY. Down-counter cnt is ceil(log2(MUL_LATENCY)) bits wide.
- IDLE → MUL_BUSY when mulE=1 and branch_takenM=0. In that cycle: mul_start=1, cnt←MUL_LATENCY-1.
- MUL_BUSY: cnt decrements every cycle. When cnt==1, the next state is IDLE.
- mulE is ignored while in MUL_BUSY, so the same instruction never restarts the multiplier.
- Hazard conditions:
  - mul_stall = (IDLE & mulE & !branch_takenM) | (MUL_BUSY & cnt>1).
  - load_use = MemReadE & rtE≠0 & (rtE==rsD | (useRtD & rtE==rtD)).
- Resolution, highest priority first; exactly one action applies per cycle:
  1. branch_takenM: PC_load=1, EN1=EN2=1, flushD=flushE=flushM=1. Suppresses mul_start.
  2. mul_stall: PC_load=0, EN1=0, EN2=0, flushM=1. The front end holds; bubbles enter MA.
  3. load_use: PC_load=0, EN1=0, EN2=1, flushE=1. One bubble enters EX.
  4. select_jumpD: PC_load=1, EN1=EN2=1, flushD=1. A jump blocked by actions 2 or 3 is retried once they release.
  5. Otherwise: PC_load=1, EN1=EN2=1, all flushes 0.
- stall_count increments on each cycle with PC_load=0 and saturates at 2^CNT_W-1.
- Reset, asynchronous and held for its full duration: state=IDLE, cnt=0, stall_count=0, PC_load=0, EN1=EN2=0, flushD=flushE=flushM=1, mul_start=0, mul_busy=0.
- Reset asserted mid-MUL_BUSY aborts the sequence. After release the FSM is in IDLE.

## Timing
- All hazard outputs are combinational from the current state and inputs. There is no extra latency; they act in the same cycle as the hazard.
- A MUL occupies EX for exactly MUL_LATENCY cycles: a stall of MUL_LATENCY-1 cycles, then release on cycle MUL_LATENCY, when EX/MA captures the product.
- Back-to-back MULs: the second enters EX in the cycle after release, the FSM is in IDLE, and it starts immediately with no gap cycle.
- A load-use stall lasts exactly 1 cycle. The load moves to MA, so the condition clears.
- mul_busy and stall_count are registered-state derived and glitch-free.

## Structure
- Shared package mips_pkg holds the opcode, funct and ALUOp constants (ALU_MUL=3'b010) and the FSM state enum.
- The saturating counter is one natural sub-module: sat_counter, parameterised by width, with enable and async reset.
- Everything else stays in one module.

## Test plan
- Load-use: lw with rtE=5, MemReadE=1 while the ID instruction has rsD=5 → one cycle of PC_load=0, EN1=0, flushE=1. With rtE=0 → no stall.
- MUL, MUL_LATENCY=4: mulE held 4 cycles → mul_start pulse in cycle 0, PC_load=0 in cycles 0–2, release in cycle 3, stall_count=3.
- Two consecutive MULs → mul_start in cycles 0 and 4, total of 6 stall cycles, FSM back in IDLE in cycle 8.
- branch_takenM=1 in the same cycle as mulE=1 → flushD/E/M=1, mul_start=0, FSM stays IDLE.
- Load-use coincident with select_jumpD → stall first with flushD=0. Next cycle flushD=1 and PC_load=1.
- rst pulsed during MUL_BUSY with cnt=2 → outputs go immediately to reset values. After release: IDLE, stall_count=0. With CNT_W=2, 5 stall cycles → stall_count saturates at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core constants: opcodes, funct codes, ALUOp encodings and the
// hazard controller FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_FN  = 3'b011;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/mips_hazard_controller_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_INC = W'(1);

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_INC;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mips_hazard_controller.sv
// Pipeline hazard/stall sequencer: load-use, multi-cycle MUL pacing,
// taken-branch and jump flushes, plus a stall-cycle performance counter.
module mips_hazard_controller
    import mips_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             useRtD,
    input  logic             mulE,
    input  logic             branch_takenM,
    input  logic             select_jumpD,
    output logic             PC_load,
    output logic             EN_to_pipelineReg1,
    output logic             EN_to_pipelineReg2,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int CNT_BITS = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MUL_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    hz_state_e             state_r;
    hz_state_e             state_nxt_s;
    logic [CNT_BITS-1:0]   cnt_r;
    logic [CNT_BITS-1:0]   cnt_nxt_s;
    logic                  mul_go_s;
    logic                  mul_stall_s;
    logic                  load_use_s;

    // MUL pacing FSM state and down-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_BITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; mulE is only sampled in IDLE so a MUL never restarts itself.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mul_go_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mulE && !branch_takenM) begin
                    state_nxt_s = ST_MUL_BUSY;
                    cnt_nxt_s   = CNT_LOAD;
                    mul_go_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MUL_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_BITS{1'b0}};
            end
        endcase
    end

    assign mul_stall_s = mul_go_s || ((state_r == ST_MUL_BUSY) && (cnt_r > CNT_ONE));
    assign load_use_s  = MemReadE && (rtE != 5'd0) &&
                         ((rtE == rsD) || (useRtD && (rtE == rtD)));
    assign mul_busy    = (state_r == ST_MUL_BUSY);

    // Prioritised hazard resolution; reset forces the safe hold/flush pattern.
    always_comb begin
        PC_load            = 1'b1;
        EN_to_pipelineReg1 = 1'b1;
        EN_to_pipelineReg2 = 1'b1;
        flushD             = 1'b0;
        flushE             = 1'b0;
        flushM             = 1'b0;
        mul_start          = 1'b0;
        if (rst) begin
            PC_load            = 1'b0;
            EN_to_pipelineReg1 = 1'b0;
            EN_to_pipelineReg2 = 1'b0;
            flushD             = 1'b1;
            flushE             = 1'b1;
            flushM             = 1'b1;
        end else if (branch_takenM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mul_stall_s) begin
            PC_load            = 1'b0;
            EN_to_pipelineReg1 = 1'b0;
            EN_to_pipelineReg2 = 1'b0;
            flushM             = 1'b1;
            mul_start          = mul_go_s;
        end else if (load_use_s) begin
            PC_load            = 1'b0;
            EN_to_pipelineReg1 = 1'b0;
            flushE             = 1'b1;
        end else if (select_jumpD) begin
            flushD = 1'b1;
        end else begin
            flushD = 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (!PC_load),
        .count(stall_count)
    );

endmodule

// File: tb/tb_mips_hazard_controller.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge monitor
// pops and compares against the default DUT and a CNT_W=2 saturation instance.
module tb_mips_hazard_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadE = 1'b0;
    logic [4:0]  rtE = 5'd0;
    logic [4:0]  rsD = 5'd0;
    logic [4:0]  rtD = 5'd0;
    logic        useRtD = 1'b0;
    logic        mulE = 1'b0;
    logic        branch_takenM = 1'b0;
    logic        select_jumpD = 1'b0;

    logic        PC_load, EN1, EN2, flushD, flushE, flushM, mul_start, mul_busy;
    logic [31:0] stall_count;
    logic        s_PC_load, s_EN1, s_EN2, s_flushD, s_flushE, s_flushM, s_mul_start, s_mul_busy;
    logic [1:0]  s_stall_count;

    always #5 clk = ~clk;

    mips_hazard_controller #(.MUL_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .MemReadE(MemReadE), .rtE(rtE), .rsD(rsD), .rtD(rtD),
        .useRtD(useRtD), .mulE(mulE), .branch_takenM(branch_takenM), .select_jumpD(select_jumpD),
        .PC_load(PC_load), .EN_to_pipelineReg1(EN1), .EN_to_pipelineReg2(EN2),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .mul_start(mul_start), .mul_busy(mul_busy), .stall_count(stall_count)
    );

    mips_hazard_controller #(.MUL_LATENCY(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .MemReadE(MemReadE), .rtE(rtE), .rsD(rsD), .rtD(rtD),
        .useRtD(useRtD), .mulE(mulE), .branch_takenM(branch_takenM), .select_jumpD(select_jumpD),
        .PC_load(s_PC_load), .EN_to_pipelineReg1(s_EN1), .EN_to_pipelineReg2(s_EN2),
        .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM),
        .mul_start(s_mul_start), .mul_busy(s_mul_busy), .stall_count(s_stall_count)
    );

    // Flag order: {PC_load, EN1, EN2, flushD, flushE, flushM, mul_start, mul_busy}
    localparam logic [7:0] F_RST   = 8'b0001_1100;
    localparam logic [7:0] F_NORM  = 8'b1110_0000;
    localparam logic [7:0] F_BR    = 8'b1111_1100;
    localparam logic [7:0] F_MSTRT = 8'b0000_0110;
    localparam logic [7:0] F_MBUSY = 8'b0000_0101;
    localparam logic [7:0] F_MREL  = 8'b1110_0001;
    localparam logic [7:0] F_LU    = 8'b0010_1000;
    localparam logic [7:0] F_JMP   = 8'b1111_0000;

    typedef struct {
        string       name;
        logic [7:0]  flags;
        logic [31:0] sc;
        logic [1:0]  sc2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [7:0]  got_flags;
    logic [7:0]  got_flags2;
    logic [31:0] exp_sc = 32'd0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic vec(input string name, input logic r, input logic mr,
                       input logic [4:0] rte, input logic [4:0] rsd, input logic [4:0] rtd,
                       input logic urt, input logic mul, input logic bt, input logic jd,
                       input logic [7:0] flags);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; MemReadE = mr; rtE = rte; rsD = rsd; rtD = rtd;
        useRtD = urt; mulE = mul; branch_takenM = bt; select_jumpD = jd;
        if (r) exp_sc = 32'd0;
        e.name  = name;
        e.flags = flags;
        e.sc    = exp_sc;
        e.sc2   = (exp_sc > 32'd3) ? 2'd3 : exp_sc[1:0];
        sb_q.push_back(e);
        if (!r && !flags[7]) exp_sc = exp_sc + 32'd1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e      = sb_q.pop_front();
            got_flags  = {PC_load, EN1, EN2, flushD, flushE, flushM, mul_start, mul_busy};
            got_flags2 = {s_PC_load, s_EN1, s_EN2, s_flushD, s_flushE, s_flushM, s_mul_start, s_mul_busy};
            total_cnt++;
            if (got_flags === mon_e.flags && got_flags2 === mon_e.flags &&
                stall_count === mon_e.sc && s_stall_count === mon_e.sc2) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got flags=%b/%b sc=%0d sc2=%0d, expected flags=%b sc=%0d sc2=%0d",
                         mon_e.name, got_flags, got_flags2, stall_count, s_stall_count,
                         mon_e.flags, mon_e.sc, mon_e.sc2);
            end
        end
    end

    initial begin
        //   name          rst mr  rtE    rsD    rtD    urt mul bt  jd  flags
        vec("reset0",      1, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_RST);
        vec("reset1",      1, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_RST);
        vec("idle",        0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);
        vec("lu_rs",       0, 1, 5'd5,  5'd5,  5'd1,  0,  0,  0,  0, F_LU);
        vec("lu_clear",    0, 0, 5'd5,  5'd5,  5'd1,  0,  0,  0,  0, F_NORM);
        vec("lu_r0",       0, 1, 5'd0,  5'd0,  5'd0,  1,  0,  0,  0, F_NORM);
        vec("lu_rt",       0, 1, 5'd7,  5'd2,  5'd7,  1,  0,  0,  0, F_LU);
        vec("lu_rt_nouse", 0, 1, 5'd7,  5'd2,  5'd7,  0,  0,  0,  0, F_NORM);
        vec("mul_c0",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MSTRT);
        vec("mul_c1",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("mul_c2",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("mul_c3",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MREL);
        vec("mul_done",    0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);
        vec("b2b_c0",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MSTRT);
        vec("b2b_c1",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("b2b_c2",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("b2b_c3",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MREL);
        vec("b2b_c4",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MSTRT);
        vec("b2b_c5",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("b2b_c6",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("b2b_c7",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MREL);
        vec("b2b_c8_idle", 0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);
        vec("br_mul",      0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  1,  0, F_BR);
        vec("br_after",    0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);
        vec("jump",        0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  1, F_JMP);
        vec("lu_jump",     0, 1, 5'd5,  5'd5,  5'd0,  0,  0,  0,  1, F_LU);
        vec("jump_retry",  0, 0, 5'd5,  5'd5,  5'd0,  0,  0,  0,  1, F_JMP);
        vec("rmul_c0",     0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MSTRT);
        vec("rmul_c1",     0, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_MBUSY);
        vec("rmul_rst",    1, 0, 5'd0,  5'd0,  5'd0,  0,  1,  0,  0, F_RST);
        vec("rmul_rst2",   1, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_RST);
        vec("rmul_after",  0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);
        for (int i = 0; i < 5; i++) begin
            vec("sat_lu",  0, 1, 5'd9,  5'd9,  5'd0,  0,  0,  0,  0, F_LU);
        end
        vec("sat_end",     0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);
        vec("sat_hold",    0, 0, 5'd0,  5'd0,  5'd0,  0,  0,  0,  0, F_NORM);

        @(posedge clk);
        @(negedge clk);
        #1;
        total_cnt++;
        if (sb_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
